adc_frame_capture: RTL and testbench
====================================

# adc_frame_capture

Downstream of the system clock generator: captures the serial ADC bit streams launched by `adc_start_conv_n`/`adc_word_sync`, deserializes one sample per channel per 2 MS/s conversion period, and emits each conversion as a framed 32-bit AXI-Stream packet (header + one beat per channel) toward the XDMA C2H stream path. Runs entirely in the 40 MHz `data_clk` domain, with 20 cycles per conversion period.

## Interface
Parameters:
- `N_CH`, 8: number of ADC channels (1..16).
- `ADC_BITS`, 18: bits per sample, MSB first, two's complement (2..18, fits a 20-cycle period).

Ports:
- `data_clk`  in  1  40 MHz capture/stream clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `acq_en`  in  1  acquisition enable; while low, new word syncs are ignored.
- `clr_flags`  in  1  single-cycle pulse that clears the sticky flags.
- `adc_word_sync`  in  1  one-cycle pulse marking the start of a serial word.
- `adc_data_i`  in  N_CH  serial data, one bit per channel.
- `m_axis_tdata`  out  32  stream data.
- `m_axis_tvalid`  out  1  stream valid.
- `m_axis_tready`  in  1  stream ready.
- `m_axis_tlast`  out  1  last beat of the frame.
- `overrun`  out  1  sticky: a completed frame was dropped because the hold buffer was busy.
- `sync_err`  out  1  sticky: `adc_word_sync` arrived mid-word.
- `frame_cnt`  out  24  frames accepted into the hold buffer.

## Operation
- Shifter FSM, `WAIT_SYNC`/`SHIFT`:
  - In `WAIT_SYNC`, `adc_word_sync`=1 with `acq_en`=1 at edge k enters `SHIFT` and clears the bit counter.
  - Each channel shifts `adc_data_i[c]` in at edges k+1 .. k+ADC_BITS, MSB first.
  - After the last bit, the FSM returns to `WAIT_SYNC` and raises a 1-cycle `word_done`.
  - `adc_word_sync` during `SHIFT` discards the partial word, sets `sync_err` and restarts the shift, with edge k taken as the new sync.
  - `acq_en` falling during `SHIFT` does not abort; the word completes.
- Hold buffer:
  - On `word_done`, if the stream FSM is `IDLE`, all N_CH words are copied into the hold registers and `frame_cnt` increments (wraps at 2^24-1 -> 0).
  - Otherwise the word is dropped, `overrun` is set and `frame_cnt` is unchanged.
- Stream FSM, `IDLE` -> `HDR` -> `DATA` -> `IDLE`:
  - `HDR` beat: {8'hA5, frame_cnt value after increment}.
  - `DATA` beats: channel c = 0..N_CH-1, tdata = {c[3:0], sign-extend(sample_c) to 28 bits}; `tlast`=1 on c = N_CH-1.
  - A beat advances only when tvalid && tready; tdata/tlast are stable while tvalid=1 and tready=0.
  - After the last handshake the FSM returns to `IDLE`; tvalid drops unless a new frame loads that same edge.
- Flags: `clr_flags` clears `overrun`/`sync_err`. If a set event occurs in the same cycle, set wins.

## Timing
- Reset values: tvalid=0, tlast=0, tdata=0, overrun=0, sync_err=0, frame_cnt=0; both FSMs idle; shift registers 0.
- Latency:
  - Sync at edge k; last bit sampled at edge k+ADC_BITS.
  - Hold buffer loaded and tvalid=1 (header) at edge k+ADC_BITS+1.
  - With tready held at 1, tlast is seen at edge k+ADC_BITS+1+N_CH.
- Throughput: with tready=1, N_CH+1 ≤ 20 beats per period, so no overrun at 2 MS/s.
- Simultaneous events:
  - `word_done` coincides with the final handshake: the new frame loads, with no overrun and no idle cycle.
  - `adc_word_sync` coincides with `word_done`: the completed word is kept and a new shift starts.
- Reset mid-packet: outputs go to reset values immediately (async). The partial packet is abandoned; downstream must tolerate this.

## Structure
- Package `adc_capture_pkg`: `FRAME_MARKER` = 8'hA5, `TDATA_W` = 32, `FRAME_CNT_W` = 24, `CH_IDX_W` = 4, and the shifter/stream FSM state enums.
- Sub-module `adc_serial_shifter`: N_CH shift registers, bit counter, `WAIT_SYNC`/`SHIFT` FSM, `sync_err` detect, `word_done`/words outputs.
- The top level holds the hold buffer, stream FSM, flags and `frame_cnt`.

## Test plan
- Single frame: N_CH=8, ADC_BITS=18, ch c sends 18'h20000+c, tready=1 -> beats A5000001, then {c, 28'hFFE0000+c}; tlast on the 9th beat, first beat at sync+19.
- Backpressure: tready toggles 1/0 each cycle -> tdata/tlast stable while stalled; all 9 beats delivered in order; no overrun at 2 MS/s.
- Overrun: tready=0 across two sync periods -> second frame dropped, `overrun`=1, `frame_cnt`=1; after `clr_flags`, overrun=0.
- Mid-word sync: extra `adc_word_sync` 5 cycles after the first -> `sync_err`=1; the emitted frame contains bits from the second sync only.
- `acq_en` drop mid-shift -> current frame is emitted; subsequent syncs produce no frames.
- Reset mid-packet after 3 beats -> tvalid=0 immediately; `frame_cnt`=0; the next sync yields header A5000001.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared constants and state encodings for the ADC frame capture path.
package adc_capture_pkg;

    localparam logic [7:0] FRAME_MARKER = 8'hA5;
    localparam int         TDATA_W      = 32;
    localparam int         FRAME_CNT_W  = 24;
    localparam int         CH_IDX_W     = 4;
    localparam int         SAMPLE_W     = TDATA_W - CH_IDX_W;

    typedef enum logic {
        SH_WAIT_SYNC,
        SH_SHIFT
    } shift_state_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA
    } stream_state_e;

endpackage

// File: rtl/adc_serial_shifter.sv
// Deserializes one MSB-first word per channel after each accepted word sync.
module adc_serial_shifter
    import adc_capture_pkg::*;
#(
    parameter int N_CH     = 8,
    parameter int ADC_BITS = 18
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               acq_en_i,
    input  logic                               word_sync_i,
    input  logic [N_CH-1:0]                    data_i,
    output logic                               word_done_o,
    output logic                               sync_err_o,
    output logic [N_CH-1:0][ADC_BITS-1:0]      words_o
);

    localparam int                CNT_W    = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(ADC_BITS - 1);

    shift_state_e                     state_q;
    logic [CNT_W-1:0]                 cnt_q;
    logic [N_CH-1:0][ADC_BITS-1:0]    sr_q;
    logic                             word_done_q;
    logic                             sync_take;

    // A sync with acquisition disabled is ignored everywhere, including mid-word.
    assign sync_take   = word_sync_i & acq_en_i;
    assign sync_err_o  = sync_take && (state_q == SH_SHIFT);
    assign word_done_o = word_done_q;
    assign words_o     = sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SH_WAIT_SYNC;
            cnt_q       <= '0;
            sr_q        <= '0;
            word_done_q <= 1'b0;
        end else begin
            word_done_q <= 1'b0;
            case (state_q)
                SH_WAIT_SYNC: begin
                    if (sync_take) begin
                        state_q <= SH_SHIFT;
                        cnt_q   <= '0;
                    end
                end
                SH_SHIFT: begin
                    if (sync_take) begin
                        // Restart: the next ADC_BITS shifts overwrite the partial word.
                        cnt_q <= '0;
                    end else begin
                        for (int c = 0; c < N_CH; c++) begin
                            sr_q[c] <= {sr_q[c][ADC_BITS-2:0], data_i[c]};
                        end
                        if (cnt_q == LAST_BIT) begin
                            state_q     <= SH_WAIT_SYNC;
                            word_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= SH_WAIT_SYNC;
            endcase
        end
    end

endmodule

// File: rtl/adc_frame_capture.sv
// Captures serial ADC conversions and streams each as a header + per-channel
// AXI-Stream packet; holds one frame while it drains, dropping frames that arrive meanwhile.
module adc_frame_capture
    import adc_capture_pkg::*;
#(
    parameter int N_CH     = 8,
    parameter int ADC_BITS = 18
) (
    input  logic                    data_clk,
    input  logic                    reset_n,
    input  logic                    acq_en,
    input  logic                    clr_flags,
    input  logic                    adc_word_sync,
    input  logic [N_CH-1:0]         adc_data_i,
    output logic [TDATA_W-1:0]      m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    overrun,
    output logic                    sync_err,
    output logic [FRAME_CNT_W-1:0]  frame_cnt
);

    localparam int                   N_SLOTS = 2 ** CH_IDX_W;
    localparam logic [CH_IDX_W-1:0]  LAST_CH = CH_IDX_W'(N_CH - 1);

    logic                            word_done;
    logic                            sync_err_evt;
    logic [N_CH-1:0][ADC_BITS-1:0]   words;

    adc_serial_shifter #(
        .N_CH     (N_CH),
        .ADC_BITS (ADC_BITS)
    ) u_shifter (
        .clk         (data_clk),
        .rst_n       (reset_n),
        .acq_en_i    (acq_en),
        .word_sync_i (adc_word_sync),
        .data_i      (adc_data_i),
        .word_done_o (word_done),
        .sync_err_o  (sync_err_evt),
        .words_o     (words)
    );

    stream_state_e                   state_q;
    logic [N_CH-1:0][ADC_BITS-1:0]   hold_q;
    logic [CH_IDX_W-1:0]             ch_q;
    logic [TDATA_W-1:0]              tdata_q;
    logic                            tvalid_q;
    logic                            tlast_q;
    logic [FRAME_CNT_W-1:0]          frame_cnt_q;
    logic                            overrun_q;
    logic                            sync_err_q;

    logic [TDATA_W-1:0]              beat_w [N_SLOTS];
    logic [CH_IDX_W-1:0]             ch_nxt;
    logic [FRAME_CNT_W-1:0]          frame_cnt_inc;
    logic                            hs;
    logic                            final_hs;
    logic                            accept;

    // Beat table is padded to a power of two so the channel index needs no range guard.
    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_beat
            if (gi < N_CH) begin : g_used
                assign beat_w[gi] = {CH_IDX_W'(gi),
                                     {(SAMPLE_W - ADC_BITS){hold_q[gi][ADC_BITS-1]}},
                                     hold_q[gi]};
            end else begin : g_pad
                assign beat_w[gi] = '0;
            end
        end
    endgenerate

    assign ch_nxt        = ch_q + 1'b1;
    assign frame_cnt_inc = frame_cnt_q + 1'b1;
    assign hs            = tvalid_q & m_axis_tready;
    assign final_hs      = (state_q == ST_DATA) && hs && tlast_q;
    // A frame completing on the last handshake loads back-to-back with no idle beat.
    assign accept        = word_done && ((state_q == ST_IDLE) || final_hs);

    always_ff @(posedge data_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            ch_q        <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else if (accept) begin
            hold_q      <= words;
            frame_cnt_q <= frame_cnt_inc;
            state_q     <= ST_HDR;
            tdata_q     <= {FRAME_MARKER, frame_cnt_inc};
            tvalid_q    <= 1'b1;
            tlast_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_HDR: begin
                    if (hs) begin
                        state_q <= ST_DATA;
                        ch_q    <= '0;
                        tdata_q <= beat_w[0];
                        tlast_q <= (N_CH == 1);
                    end
                end
                ST_DATA: begin
                    if (hs) begin
                        if (tlast_q) begin
                            state_q  <= ST_IDLE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                        end else begin
                            ch_q    <= ch_nxt;
                            tdata_q <= beat_w[ch_nxt];
                            tlast_q <= (ch_nxt == LAST_CH);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge data_clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            if (word_done && !accept) begin
                overrun_q <= 1'b1;
            end else if (clr_flags) begin
                overrun_q <= 1'b0;
            end
            if (sync_err_evt) begin
                sync_err_q <= 1'b1;
            end else if (clr_flags) begin
                sync_err_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign overrun       = overrun_q;
    assign sync_err      = sync_err_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Directed bench for adc_frame_capture: a frame-level model predicts every beat and flag.
`timescale 1ns/1ps
module tb_adc_frame_capture;

    localparam int N_CH     = 8;
    localparam int ADC_BITS = 18;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              acq_en    = 1'b0;
    logic              clr_flags = 1'b0;
    logic              sync      = 1'b0;
    logic [N_CH-1:0]   din       = '0;
    logic              tready    = 1'b1;
    logic [31:0]       tdata;
    logic              tvalid;
    logic              tlast;
    logic              overrun;
    logic              sync_err;
    logic [23:0]       frame_cnt;

    adc_frame_capture #(.N_CH(N_CH), .ADC_BITS(ADC_BITS)) dut (
        .data_clk      (clk),
        .reset_n       (reset_n),
        .acq_en        (acq_en),
        .clr_flags     (clr_flags),
        .adc_word_sync (sync),
        .adc_data_i    (din),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .overrun       (overrun),
        .sync_err      (sync_err),
        .frame_cnt     (frame_cnt)
    );

    always #12 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Edge counter: after posedge number e has settled, cyc == e.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [23:0] exp_fc   = '0;
    logic        exp_ovr  = 1'b0;
    logic        exp_serr = 1'b0;

    // Completed words announced by the stimulus: edge at which the frame should load.
    int          pend_edge [64];
    logic [17:0] pend_samp [64][N_CH];
    int          wr_ptr       = 0;
    int          rd_ptr       = 0;
    int          midsync_edge = -1;

    logic [17:0] samp [N_CH];
    int          rmode = 0;

    always @(posedge clk or negedge reset_n) begin : model
        if (!reset_n) begin
            exp_q.delete();
            exp_fc   = '0;
            exp_ovr  = 1'b0;
            exp_serr = 1'b0;
            rd_ptr   = wr_ptr;
        end else begin
            int  e;
            bit  ovr_set;
            e       = cyc + 1;
            ovr_set = 1'b0;
            if (exp_q.size() > 0 && tready) void'(exp_q.pop_front());
            if (rd_ptr != wr_ptr && pend_edge[rd_ptr % 64] == e) begin
                if (exp_q.size() == 0) begin
                    exp_fc = exp_fc + 24'd1;
                    exp_q.push_back('{d: {8'hA5, exp_fc}, last: 1'b0});
                    for (int c = 0; c < N_CH; c++) begin
                        int s;
                        s = int'(pend_samp[rd_ptr % 64][c]);
                        if (s >= (1 << (ADC_BITS - 1))) s = s - (1 << ADC_BITS);
                        exp_q.push_back('{d: (32'(c) << 28) | (32'(s) & 32'h0FFF_FFFF),
                                          last: (c == N_CH - 1)});
                    end
                end else begin
                    ovr_set = 1'b1;
                end
                rd_ptr = rd_ptr + 1;
            end
            if (ovr_set) exp_ovr = 1'b1;
            else if (clr_flags) exp_ovr = 1'b0;
            if (e == midsync_edge) exp_serr = 1'b1;
            else if (clr_flags) exp_serr = 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        if (reset_n) begin
            chk("tvalid", 32'(tvalid), 32'(exp_q.size() > 0));
            if (tvalid && exp_q.size() > 0) begin
                chk("tdata", tdata, exp_q[0].d);
                chk("tlast", 32'(tlast), 32'(exp_q[0].last));
            end
            chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
            chk("overrun", 32'(overrun), 32'(exp_ovr));
            chk("sync_err", 32'(sync_err), 32'(exp_serr));
        end
    end

    logic [31:0] log_d [256];
    logic        log_l [256];
    int          log_e [256];
    int          log_n = 0;

    always @(posedge clk) begin : logger
        if (reset_n && tvalid && tready && log_n < 256) begin
            log_d[log_n] = tdata;
            log_l[log_n] = tlast;
            log_e[log_n] = cyc + 1;
            $display("beat %0d: edge %0d tdata %h tlast %0d", log_n, cyc + 1, tdata, tlast);
            log_n = log_n + 1;
        end
    end

    always @(negedge clk) begin : ready_drv
        case (rmode)
            0:       tready = 1'b1;
            1:       tready = ~tready;
            default: tready = 1'b0;
        endcase
    end

    task automatic send_word(input int nbits, input bit mid, input int drop_at,
                             input int gap, output int k);
        bit take;
        @(negedge clk);
        sync = 1'b1;
        din  = '0;
        k    = cyc + 1;
        take = acq_en;
        if (mid) midsync_edge = k;
        for (int b = 0; b < nbits; b++) begin
            @(negedge clk);
            sync = 1'b0;
            if (b == drop_at) acq_en = 1'b0;
            for (int c = 0; c < N_CH; c++) din[c] = samp[c][ADC_BITS-1-b];
        end
        if (take && nbits == ADC_BITS) begin
            pend_edge[wr_ptr % 64] = k + ADC_BITS + 1;
            pend_samp[wr_ptr % 64] = samp;
            wr_ptr = wr_ptr + 1;
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            sync = 1'b0;
            din  = '0;
        end
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (!(rd_ptr == wr_ptr && exp_q.size() == 0 && tvalid == 1'b0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("drain_timeout", 32'(i >= budget), 32'd0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        int base;
        int i;

        for (int c = 0; c < N_CH; c++) samp[c] = 18'h20000 + 18'(c);

        repeat (3) @(negedge clk);
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        reset_n = 1'b1;
        acq_en  = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame, tready high.
        base = log_n;
        send_word(ADC_BITS, 1'b0, -1, 1, k);
        wait_drain(100);
        chk("single_nbeats", 32'(log_n - base), 32'd9);
        chk("single_hdr", log_d[base], 32'hA500_0001);
        chk("single_ch0", log_d[base+1], 32'h0FFE_0000);
        chk("single_ch7", log_d[base+8], 32'h7FFE_0007);
        chk("single_tlast", 32'(log_l[base+8]), 32'd1);
        chk("single_first_hs", 32'(log_e[base] - k), 32'd20);
        chk("single_last_hs", 32'(log_e[base+8] - k), 32'd28);

        // Backpressure, two frames at the full 2 MS/s rate.
        rmode = 1;
        for (int c = 0; c < N_CH; c++)
            samp[c] = (c % 2 == 1) ? 18'(c * 18'h0333) : 18'h3FFFF - 18'(c * 3);
        base = log_n;
        send_word(ADC_BITS, 1'b0, -1, 1, k);
        for (int c = 0; c < N_CH; c++) samp[c] = 18'h1FFFF - 18'(c);
        send_word(ADC_BITS, 1'b0, -1, 1, k);
        wait_drain(200);
        chk("bp_nbeats", 32'(log_n - base), 32'd18);
        chk("bp_overrun", 32'(overrun), 32'd0);

        // Overrun: sink stalled across two periods.
        rmode = 2;
        for (int c = 0; c < N_CH; c++) samp[c] = 18'h00100 + 18'(c);
        send_word(ADC_BITS, 1'b0, -1, 1, k);
        send_word(ADC_BITS, 1'b0, -1, 1, k);
        repeat (4) @(negedge clk);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_frame_cnt", 32'(frame_cnt), 32'd4);
        pulse_clr();
        @(negedge clk);
        chk("ovr_cleared", 32'(overrun), 32'd0);
        rmode = 0;
        wait_drain(100);

        // Mid-word sync: only the second word is framed.
        rmode = 0;
        for (int c = 0; c < N_CH; c++) samp[c] = 18'h3FFFF;
        send_word(4, 1'b0, -1, 0, k);
        for (int c = 0; c < N_CH; c++) samp[c] = 18'h00123 + 18'(c);
        base = log_n;
        send_word(ADC_BITS, 1'b1, -1, 1, k);
        wait_drain(100);
        chk("mid_sync_err", 32'(sync_err), 32'd1);
        chk("mid_hdr", log_d[base], 32'hA500_0005);
        chk("mid_ch0", log_d[base+1], 32'h0000_0123);
        pulse_clr();

        // acq_en drop mid-shift: word completes, later syncs are ignored.
        base = log_n;
        for (int c = 0; c < N_CH; c++) samp[c] = 18'h2ABCD;
        send_word(ADC_BITS, 1'b0, 5, 1, k);
        send_word(ADC_BITS, 1'b0, -1, 1, k);
        send_word(ADC_BITS, 1'b0, -1, 1, k);
        wait_drain(100);
        chk("acq_nbeats", 32'(log_n - base), 32'd9);
        chk("acq_frame_cnt", 32'(frame_cnt), 32'd6);
        acq_en = 1'b1;

        // Reset in the middle of a packet.
        base = log_n;
        for (int c = 0; c < N_CH; c++) samp[c] = 18'h00042;
        send_word(ADC_BITS, 1'b0, -1, 0, k);
        i = 0;
        while (log_n < base + 3 && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("rstmid_timeout", 32'(i >= 100), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_tvalid", 32'(tvalid), 32'd0);
        chk("rstmid_tdata", tdata, 32'd0);
        chk("rstmid_frame_cnt", 32'(frame_cnt), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        base = log_n;
        send_word(ADC_BITS, 1'b0, -1, 1, k);
        wait_drain(100);
        chk("rstmid_hdr", log_d[base], 32'hA500_0001);
        chk("rstmid_ch3", log_d[base+4], 32'h3000_0042);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
